// File: rtl/nodf_status_pkg.sv
// nodf_status_pkg
// Shared definitions for the non-dataflow module status tracker:
//   - nodf_state_e : 2-bit execution state reported to the status dump
//   - CNT_W_DEFAULT: default width of event counters and the cycle timestamp
//   - sat_inc      : saturating increment usable for any counter width up to SAT_W
package nodf_status_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        DONE_WAIT = 2'd2,
        FINISHED  = 2'd3
    } nodf_state_e;

    localparam int CNT_W_DEFAULT = 32;

    // Widest counter the helper below can handle.
    localparam int SAT_W = 64;

    // Increment value, holding at the all-ones pattern of a width-bit counter.
    // Callers zero-extend into SAT_W bits and truncate the result back.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned     width);
        logic [SAT_W-1:0] max_val;
        max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
        return (value >= max_val) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/nodf_module_intf_tracker_fifo.sv
// nodf_ts_fifo
// Synchronous timestamp FIFO holding the accept time of each outstanding
// transaction. Push and pop may occur in the same cycle; a push while full is
// accepted only when a pop frees a slot in that same cycle.
// Ports:
//   clock, reset          sampling clock, asynchronous active-high reset
//   push, push_data       write request and timestamp
//   pop, pop_data         read request and oldest timestamp (valid when !empty)
//   full, empty, count    occupancy status
module nodf_ts_fifo
    import nodf_status_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nodf_module_intf_tracker.sv
// nodf_module_intf_tracker
// Passive cycle-level tracker for one non-dataflow HLS module's block-level
// handshake. Reports execution state, transaction counts and per-transaction
// latency; never drives the observed module. All outputs are registered.
// Optional macro NODF_LAT_STATS_EN adds lat_min / lat_max outputs.
// Ports:
//   clock, reset                         sampling clock, async active-high reset
//   ap_start/ap_ready/ap_done/ap_continue observed handshake
//   finish                               end of simulation (sticky)
//   state                                0 IDLE, 1 BUSY, 2 DONE_WAIT, 3 FINISHED
//   start_cnt/ready_cnt/done_cnt         saturating event counters
//   in_flight                            accepted but not yet consumed
//   last_lat, lat_valid                  latest latency and its update pulse
//   overflow, underflow                  sticky tracking errors
//   lat_min, lat_max                     latency extremes (NODF_LAT_STATS_EN only)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing outstanding, no completion pending
// BUSY      | at least one accepted start not yet consumed
// DONE_WAIT | ap_done asserted but held off by ap_continue low
// FINISHED  | finish seen; counters and flags frozen until reset
module nodf_module_intf_tracker
    import nodf_status_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic                          ap_ready,
    input  logic                          ap_done,
    input  logic                          ap_continue,
    input  logic                          finish,
    output logic [1:0]                    state,
    output logic [CNT_W-1:0]              start_cnt,
    output logic [CNT_W-1:0]              ready_cnt,
    output logic [CNT_W-1:0]              done_cnt,
    output logic [$clog2(MAX_INFLIGHT):0] in_flight,
    output logic [CNT_W-1:0]              last_lat,
    output logic                          lat_valid,
`ifdef NODF_LAT_STATS_EN
    output logic [CNT_W-1:0]              lat_min,
    output logic [CNT_W-1:0]              lat_max,
`endif
    output logic                          overflow,
    output logic                          underflow
);

    localparam int IW = $clog2(MAX_INFLIGHT) + 1;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(SAT_W'(value), CNT_W));
    endfunction

    nodf_state_e      state_q;
    nodf_state_e      state_d;
    logic [CNT_W-1:0] now_q;

    logic             accept;
    logic             consume;
    logic             active;
    logic             fifo_push;
    logic             fifo_pop;
    logic             bypass;
    logic             ovf_evt;
    logic             unf_evt;
    logic             lat_evt;
    logic [CNT_W-1:0] lat_new;
    logic [CNT_W-1:0] fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IW-1:0]    fifo_count;
    logic [IW-1:0]    in_flight_next;

    assign accept  = ap_start & ap_ready;
    assign consume = ap_done & ap_continue;
    assign active  = (state_q != FINISHED);

    // An accept and consume in the same cycle with nothing outstanding is a
    // zero-latency transaction: it bypasses the FIFO entirely.
    assign fifo_pop  = active & consume & ~fifo_empty;
    assign bypass    = active & accept & consume & fifo_empty;
    // A full FIFO can still take a timestamp if a pop frees a slot this cycle.
    assign fifo_push = active & accept & ~bypass & (~fifo_full | fifo_pop);
    assign ovf_evt   = active & accept & fifo_full & ~fifo_pop;
    assign unf_evt   = active & consume & fifo_empty & ~accept;
    assign lat_evt   = fifo_pop | bypass;
    assign lat_new   = fifo_pop ? (now_q - fifo_data) : '0;

    nodf_ts_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (CNT_W)
    ) u_ts_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (now_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_flight = fifo_count;

    always_comb begin
        in_flight_next = fifo_count;
        if (fifo_push && !fifo_pop) begin
            in_flight_next = fifo_count + IW'(1);
        end else if (fifo_pop && !fifo_push) begin
            in_flight_next = fifo_count - IW'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state, priority FINISHED > DONE_WAIT > BUSY > IDLE
    always_comb begin
        state_d = IDLE;
        if (!active || finish) begin
            state_d = FINISHED;
        end else if (ap_done && !ap_continue) begin
            state_d = DONE_WAIT;
        end else if (in_flight_next != '0) begin
            state_d = BUSY;
        end
    end

    // FSM: outputs
    always_comb begin
        state = state_q;
    end

    // Timestamp keeps running after finish; only the reported values freeze.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            now_q     <= '0;
            start_cnt <= '0;
            ready_cnt <= '0;
            done_cnt  <= '0;
            last_lat  <= '0;
            lat_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            now_q     <= inc(now_q);
            lat_valid <= lat_evt;
            if (active) begin
                if (accept) begin
                    start_cnt <= inc(start_cnt);
                end
                if (ap_ready) begin
                    ready_cnt <= inc(ready_cnt);
                end
                if (consume) begin
                    done_cnt <= inc(done_cnt);
                end
                if (ovf_evt) begin
                    overflow <= 1'b1;
                end
                if (unf_evt) begin
                    underflow <= 1'b1;
                end
                if (lat_evt) begin
                    last_lat <= lat_new;
                end
            end
        end
    end

`ifdef NODF_LAT_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_min <= '1;
            lat_max <= '0;
        end else if (lat_evt) begin
            if (lat_new < lat_min) begin
                lat_min <= lat_new;
            end
            if (lat_new > lat_max) begin
                lat_max <= lat_new;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nodf_module_intf_tracker.sv
module tb_nodf_module_intf_tracker;

    localparam int CNT_W        = 32;
    localparam int MAX_INFLIGHT = 4;

    logic             clock;
    logic             reset;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             finish;
    logic [1:0]       state;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] ready_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [2:0]       in_flight;
    logic [CNT_W-1:0] last_lat;
    logic             lat_valid;
    logic             overflow;
    logic             underflow;
`ifdef NODF_LAT_STATS_EN
    logic [CNT_W-1:0] lat_min;
    logic [CNT_W-1:0] lat_max;
`endif

    nodf_module_intf_tracker #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .finish      (finish),
        .state       (state),
        .start_cnt   (start_cnt),
        .ready_cnt   (ready_cnt),
        .done_cnt    (done_cnt),
        .in_flight   (in_flight),
        .last_lat    (last_lat),
        .lat_valid   (lat_valid),
`ifdef NODF_LAT_STATS_EN
        .lat_min     (lat_min),
        .lat_max     (lat_max),
`endif
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One vector = inputs for one clock edge + outputs expected after it.
    // in = {ap_start, ap_ready, ap_done, ap_continue, finish}
    typedef struct {
        bit         rst;
        logic [4:0] in;
        int         st, sc, rc, dc, inf, lat, lv, ov, un;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input bit rst, input logic [4:0] in, input int st, input int sc,
                       input int rc, input int dc, input int inf, input int lat,
                       input int lv, input int ov, input int un);
        vec_t v;
        v.rst = rst; v.in = in; v.st = st; v.sc = sc; v.rc = rc; v.dc = dc;
        v.inf = inf; v.lat = lat; v.lv = lv; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {ap_start, ap_ready, ap_done, ap_continue, finish} = 5'b0;
        #2;
        reset = 1'b0;
    endtask

    task automatic step(input logic [4:0] in);
        {ap_start, ap_ready, ap_done, ap_continue, finish} = in;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input int idx, input int st, input int sc, input int rc,
                           input int dc, input int inf, input int lat, input int lv,
                           input int ov, input int un);
        chk("state",     idx, state,     st);
        chk("start_cnt", idx, start_cnt, sc);
        chk("ready_cnt", idx, ready_cnt, rc);
        chk("done_cnt",  idx, done_cnt,  dc);
        chk("in_flight", idx, in_flight, inf);
        chk("last_lat",  idx, last_lat,  lat);
        chk("lat_valid", idx, lat_valid, lv);
        chk("overflow",  idx, overflow,  ov);
        chk("underflow", idx, underflow, un);
    endtask

    initial begin
        reset = 1'b1;
        {ap_start, ap_ready, ap_done, ap_continue, finish} = 5'b0;

        //  rst  s r d c f   st sc rc dc if lat lv ov un
        // 1: idle after reset
        add(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // 2: accept at edge 2, consume at edge 7 -> latency 5
        add(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 5'b11000, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 5'b00000, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00110, 0, 1, 1, 1, 0, 5, 1, 0, 0);
        add(0, 5'b00000, 0, 1, 1, 1, 0, 5, 0, 0, 0);
        // 3: done held with continue low for 3 cycles
        add(1, 5'b11000, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00100, 2, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00100, 2, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00100, 2, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00110, 0, 1, 1, 1, 0, 4, 1, 0, 0);
        add(0, 5'b00000, 0, 1, 1, 1, 0, 4, 0, 0, 0);
        // 4: five accepts into a 4-deep tracker, then one consume
        add(1, 5'b11000, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b11000, 1, 2, 2, 0, 2, 0, 0, 0, 0);
        add(0, 5'b11000, 1, 3, 3, 0, 3, 0, 0, 0, 0);
        add(0, 5'b11000, 1, 4, 4, 0, 4, 0, 0, 0, 0);
        add(0, 5'b11000, 1, 5, 5, 0, 4, 0, 0, 1, 0);
        add(0, 5'b00110, 1, 5, 5, 1, 3, 5, 1, 1, 0);
        // 5: underflow keeps last_lat; bypass from empty gives latency 0
        add(1, 5'b11000, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00000, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00110, 0, 1, 1, 1, 0, 2, 1, 0, 0);
        add(0, 5'b00110, 0, 1, 1, 2, 0, 2, 0, 0, 1);
        add(0, 5'b11110, 0, 2, 2, 3, 0, 0, 1, 0, 1);
        add(0, 5'b00000, 0, 2, 2, 3, 0, 0, 0, 0, 1);
        // 6: ready-only observation, then finish freezes counters
        add(1, 5'b01000, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 5'b00000, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 5'b01000, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 5'b01000, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 5'b00001, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 5'b01000, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 5'b11000, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        // event in the finish cycle still counts, later ones do not
        add(1, 5'b11001, 3, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 5'b00110, 3, 1, 1, 0, 1, 0, 0, 0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
                chk_all(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            step(vecs[i].in);
            chk_all(i, vecs[i].st, vecs[i].sc, vecs[i].rc, vecs[i].dc, vecs[i].inf,
                    vecs[i].lat, vecs[i].lv, vecs[i].ov, vecs[i].un);
        end

        // Reset mid-transaction: asynchronous clear, outstanding timestamps lost
        do_reset();
        step(5'b11000);
        step(5'b11000);
        chk("pre_reset_in_flight", 100, in_flight, 2);
        reset = 1'b1;
        #1;
        chk("async_reset_in_flight", 101, in_flight, 0);
        chk("async_reset_start_cnt", 101, start_cnt, 0);
        chk("async_reset_state",     101, state,     0);
        #1;
        reset = 1'b0;
        step(5'b00110);
        chk_all(102, 0, 0, 0, 1, 0, 0, 0, 0, 1);

        // Timestamp run from reset: latency of a later transaction
        do_reset();
        step(5'b00000);
        step(5'b00000);
        step(5'b11000);      // accept at edge 2
        step(5'b11000);      // accept at edge 3
        step(5'b00110);      // consume at edge 4 -> 2
        chk("lat_a", 103, last_lat, 2);
        step(5'b00000);
        step(5'b00000);
        step(5'b00110);      // consume at edge 7 -> 4
        chk("lat_b", 104, last_lat, 4);
        chk("lat_b_valid", 104, lat_valid, 1);
`ifdef NODF_LAT_STATS_EN
        chk("lat_min", 105, lat_min, 2);
        chk("lat_max", 105, lat_max, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
